dac_stream_capture: RTL and testbench

DAC_STREAM_CAPTURE -- requirements
Module: dac_stream_capture

---
 rtl/dac_stream_capture_pkg.sv | 47 ++++
 rtl/dac_stream_capture_sync_fifo.sv | 65 ++++++
 rtl/dac_stream_capture.sv | 175 +++++++++++++++++
 tb/tb_dac_stream_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_stream_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dac_stream_capture_pkg                                             |
// | Register map, STATUS/CTRL bit positions and reset values shared by |
// | the RTL and the firmware.                                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package dac_stream_capture_pkg;

    localparam logic [2:0] C_ADDR_STATUS   = 3'd0;
    localparam logic [2:0] C_ADDR_CH0      = 3'd1;

    localparam int C_ST_ENABLE     = 0;
    localparam int C_ST_EMPTY      = 1;
    localparam int C_ST_FULL       = 2;
    localparam int C_ST_OVERFLOW   = 3;
    localparam int C_ST_LEVEL_LSB  = 8;

    localparam int C_CTRL_ENABLE   = 0;
    localparam int C_CTRL_CLR_OVF  = 3;
    localparam int C_CTRL_FLUSH    = 4;

    localparam logic C_ENABLE_RST     = 1'b1;
    localparam logic C_LATCH_SYNC_RST = 1'b1;
    localparam logic C_SER_SYNC_RST   = 1'b0;

    typedef struct packed {
        logic       enable;
        logic       empty;
        logic       full;
        logic       overflow;
        logic [7:0] level;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w = '0;
        w[C_ST_ENABLE]                 = s.enable;
        w[C_ST_EMPTY]                  = s.empty;
        w[C_ST_FULL]                   = s.full;
        w[C_ST_OVERFLOW]               = s.overflow;
        w[C_ST_LEVEL_LSB +: 8]         = s.level;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_stream_capture_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo                                                          |
// | Single-clock FIFO with flush; flush beats push and pop.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign level = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees the slot, so a push into a full FIFO can proceed alongside it
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && (!full || w_do_pop) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/dac_stream_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dac_stream_capture                                                 |
// | Serial DAC bus sniffer: frames per-channel latches into a FIFO     |
// | readable over a Wishbone slave.                                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dac_stream_capture
    import dac_stream_capture_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_EDGE   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ser_clk,
    input  logic                         ser_data,
    input  logic [CHANNELS-1:0]          ser_latch,
    input  logic [2:0]                   wb_addr,
    input  logic [31:0]                  wb_wdata,
    input  logic                         wb_we,
    input  logic                         wb_cyc,
    output logic [31:0]                  wb_rdata,
    output logic                         wb_ack,
    output logic                         frame_valid,
    output logic [CHANNELS*SAMPLE_W-1:0] frame_data
);
    localparam int FW = CHANNELS * SAMPLE_W;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // [0] sync1, [1] sync2, [2] history
    logic [2:0]          r_sclk;
    logic [2:0]          r_sdat;
    logic [CHANNELS-1:0] r_lat1, r_lat2, r_lath;
    logic [1:0]          r_warm;
    logic                r_shift_evt, r_shift_bit;
    logic [CHANNELS-1:0] r_latch_evt;
    logic [SAMPLE_W-1:0] r_shift;
    logic [SAMPLE_W-1:0] r_hold [CHANNELS];
    logic [CHANNELS-1:0] r_got;
    logic                r_enable, r_overflow;

    logic                w_warm, w_sclk_edge;
    logic [CHANNELS-1:0] w_latch_fall;
    logic [FW-1:0]       w_holds, w_head;
    logic [LW-1:0]       w_level;
    logic                w_full, w_empty;
    logic                w_access, w_ctrl_wr, w_pop, w_push, w_flush, w_drop;
    status_t             w_status;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_warm       = (r_warm == 2'd3);
    assign w_latch_fall = r_lath & ~r_lat2;

    generate
        if (CLK_EDGE != 0) begin : g_rise_edge
            assign w_sclk_edge = r_sclk[1] & ~r_sclk[2];
        end else begin : g_fall_edge
            assign w_sclk_edge = ~r_sclk[1] & r_sclk[2];
        end
        for (genvar i = 0; i < CHANNELS; i++) begin : g_flat
            assign w_holds[i*SAMPLE_W +: SAMPLE_W] = r_hold[i];
        end
    endgenerate

    // Edge pulses are registered so shift and latch stay aligned for the
    // pre-shift capture, and gated until the sync chains have refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk      <= {3{C_SER_SYNC_RST}};
            r_sdat      <= {3{C_SER_SYNC_RST}};
            r_lat1      <= {CHANNELS{C_LATCH_SYNC_RST}};
            r_lat2      <= {CHANNELS{C_LATCH_SYNC_RST}};
            r_lath      <= {CHANNELS{C_LATCH_SYNC_RST}};
            r_warm      <= 2'd0;
            r_shift_evt <= 1'b0;
            r_shift_bit <= 1'b0;
            r_latch_evt <= '0;
        end else begin
            r_sclk      <= {r_sclk[1:0], ser_clk};
            r_sdat      <= {r_sdat[1:0], ser_data};
            r_lat1      <= ser_latch;
            r_lat2      <= r_lat1;
            r_lath      <= r_lat2;
            if (!w_warm) r_warm <= r_warm + 2'd1;
            r_shift_evt <= w_sclk_edge && w_warm;
            r_shift_bit <= r_sdat[1];
            r_latch_evt <= w_latch_fall & {CHANNELS{w_warm}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_got       <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            for (int i = 0; i < CHANNELS; i++) r_hold[i] <= '0;
        end else begin
            if (r_shift_evt) r_shift <= SAMPLE_W'({r_shift, r_shift_bit});
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_latch_evt[i]) r_hold[i] <= r_shift;
            end
            frame_valid <= &r_got;
            if (&r_got) begin
                r_got      <= r_latch_evt;
                frame_data <= w_holds;
            end else begin
                r_got      <= r_got | r_latch_evt;
            end
        end
    end

    assign w_access  = wb_cyc && !wb_ack;
    assign w_ctrl_wr = w_access && wb_we && (wb_addr == C_ADDR_STATUS);
    assign w_pop     = w_access && !wb_we && (wb_addr == 3'(CHANNELS)) && !w_empty;
    assign w_flush   = w_ctrl_wr && wb_wdata[C_CTRL_FLUSH];
    assign w_push    = frame_valid && r_enable;
    assign w_drop    = w_push && w_full && !w_pop && !w_flush;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (frame_data),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .level     (w_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_status          = '0;
        w_status.enable   = r_enable;
        w_status.empty    = w_empty;
        w_status.full     = w_full;
        w_status.overflow = r_overflow;
        w_status.level    = 8'(w_level);
        w_rdata           = '0;
        if (wb_addr == C_ADDR_STATUS) begin
            w_rdata = pack_status(w_status);
        end else if (wb_addr <= 3'(CHANNELS) && !w_empty) begin
            w_rdata = 32'(w_head[32'(wb_addr - C_ADDR_CH0) * SAMPLE_W +: SAMPLE_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack     <= 1'b0;
            wb_rdata   <= '0;
            r_enable   <= C_ENABLE_RST;
            r_overflow <= 1'b0;
        end else begin
            wb_ack   <= w_access;
            wb_rdata <= w_access ? w_rdata : '0;
            if (w_ctrl_wr) begin
                r_enable <= wb_wdata[C_CTRL_ENABLE];
                if (wb_wdata[C_CTRL_CLR_OVF]) r_overflow <= 1'b0;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign w_unused = ^{wb_wdata[31:5], wb_wdata[2:1], r_sdat[2]};

endmodule
`default_nettype wire

// File: tb/tb_dac_stream_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dac_stream_capture                                              |
// | Directed self-checking bench: vector table plus corner sequences.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dac_stream_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_clk = 1'b0;
    logic        ser_data = 1'b0;
    logic [1:0]  ser_latch = 2'b11;
    logic [2:0]  wb_addr = 3'd0;
    logic [31:0] wb_wdata = 32'd0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;

    logic [31:0] wb_rdata, wb_rdata_r, frame_data, frame_data_r;
    logic        wb_ack, wb_ack_r, frame_valid, frame_valid_r;

    int          checks = 0;
    int          failures = 0;
    int          fv_count = 0;
    int          fv_count_r = 0;
    logic [31:0] fv_data = 32'd0;
    logic [31:0] fv_data_r = 32'd0;

    always #5 clk = ~clk;

    dac_stream_capture #(.CHANNELS(2), .SAMPLE_W(16), .FIFO_DEPTH(16), .CLK_EDGE(0)) dut (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .ser_latch(ser_latch),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
        .wb_rdata(wb_rdata), .wb_ack(wb_ack), .frame_valid(frame_valid), .frame_data(frame_data)
    );

    dac_stream_capture #(.CHANNELS(2), .SAMPLE_W(16), .FIFO_DEPTH(16), .CLK_EDGE(1)) dut_r (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .ser_latch(ser_latch),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
        .wb_rdata(wb_rdata_r), .wb_ack(wb_ack_r), .frame_valid(frame_valid_r), .frame_data(frame_data_r)
    );

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count++;
            fv_data = frame_data;
        end
        if (frame_valid_r) begin
            fv_count_r++;
            fv_data_r = frame_data_r;
        end
    end

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [31:0] exp_frame;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_word(input logic [15:0] w);
        for (int b = 15; b >= 0; b--) begin
            ser_data = w[b];
            cycles(4);
            ser_clk = 1'b1;
            cycles(4);
            ser_clk = 1'b0;
            cycles(4);
        end
    endtask

    task automatic latch(input int ch);
        ser_latch[ch] = 1'b0;
        cycles(6);
        ser_latch[ch] = 1'b1;
        cycles(6);
    endtask

    task automatic frame(input logic [15:0] w0, input logic [15:0] w1);
        shift_word(w0);
        latch(0);
        shift_word(w1);
        latch(1);
    endtask

    // Called at a negedge; holds cyc until the ack is seen.
    task automatic wb_xfer(input logic [2:0] addr, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd);
        int n;
        wb_addr  = addr;
        wb_we    = we;
        wb_wdata = wd;
        wb_cyc   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 8);
        checks++;
        if (!wb_ack) begin
            failures++;
            $display("FAIL wb_ack_timeout: got ack=%0b expected ack=1", wb_ack);
        end
        rd     = wb_rdata;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        cycles(1);
    endtask

    task automatic status_is(input string name, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(3'd0, 1'b0, 32'd0, rd);
        check(name, rd, exp);
    endtask

    // Completes a frame with latch1 so that the bus access lands on the push edge.
    task automatic aligned_frame_access(input logic [2:0] addr, input logic we, input logic [31:0] wd,
                                        output logic [31:0] rd);
        ser_latch[1] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("fv_aligned", 32'(frame_valid), 32'd1);
        wb_xfer(addr, we, wd, rd);
        ser_latch[1] = 1'b1;
        cycles(6);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected TB_RESULT");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int hit, c0;

        vecs[0] = '{w0: 16'h0000, w1: 16'hFFFF, exp_frame: 32'hFFFF0000};
        vecs[1] = '{w0: 16'hA5A5, w1: 16'h5A5A, exp_frame: 32'h5A5AA5A5};
        vecs[2] = '{w0: 16'h8001, w1: 16'h7FFE, exp_frame: 32'h7FFE8001};
        vecs[3] = '{w0: 16'hC3F0, w1: 16'h0F3C, exp_frame: 32'h0F3CC3F0};

        cycles(3);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_data", frame_data, 32'd0);
        check("rst_wb_ack", 32'(wb_ack), 32'd0);
        check("rst_wb_rdata", wb_rdata, 32'd0);
        rst = 1'b0;
        cycles(10);
        status_is("rst_status", 32'h0000_0003);

        // Basic frame with latency measurement from the completing latch.
        shift_word(16'h1234);
        latch(0);
        shift_word(16'hABCD);
        ser_latch[1] = 1'b0;
        hit = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid && hit == 0) hit = k;
        end
        @(negedge clk);
        ser_latch[1] = 1'b1;
        cycles(6);
        check("fv_latency_edges", 32'(hit), 32'd5);
        check("basic_fv_count", 32'(fv_count), 32'd1);
        check("basic_frame", fv_data, 32'hABCD1234);
        check("basic_frame_rise", fv_data_r, 32'hABCD1234);
        status_is("basic_status", 32'h0000_0101);
        wb_xfer(3'd1, 1'b0, 32'd0, rd);
        check("basic_ch0", rd, 32'h0000_1234);
        wb_xfer(3'd2, 1'b0, 32'd0, rd);
        check("basic_ch1", rd, 32'h0000_ABCD);
        status_is("basic_empty", 32'h0000_0003);
        wb_xfer(3'd2, 1'b0, 32'd0, rd);
        check("read_empty", rd, 32'd0);
        wb_xfer(3'd5, 1'b0, 32'd0, rd);
        check("unmapped_addr", rd, 32'd0);
        check("frame_data_stable", frame_data, 32'hABCD1234);

        // Repeat latch on channel 0 overwrites its hold.
        c0 = fv_count;
        shift_word(16'h1111);
        latch(0);
        shift_word(16'h2222);
        latch(0);
        shift_word(16'h3333);
        latch(1);
        check("relatch_count", 32'(fv_count - c0), 32'd1);
        check("relatch_frame", fv_data, 32'h33332222);
        wb_xfer(3'd0, 1'b1, 32'h11, rd);
        status_is("relatch_flushed", 32'h0000_0003);

        for (int v = 0; v < 4; v++) begin
            c0 = fv_count;
            frame(vecs[v].w0, vecs[v].w1);
            check("vec_fv_count", 32'(fv_count - c0), 32'd1);
            check("vec_frame", fv_data, vecs[v].exp_frame);
            status_is("vec_status", 32'h0000_0101);
            wb_xfer(3'd1, 1'b0, 32'd0, rd);
            check("vec_ch0", rd, {16'd0, vecs[v].exp_frame[15:0]});
            wb_xfer(3'd2, 1'b0, 32'd0, rd);
            check("vec_ch1", rd, {16'd0, vecs[v].exp_frame[31:16]});
        end

        // Data toggling every half period: falling edge sees 1, rising sees 0.
        for (int b = 0; b < 16; b++) begin
            ser_clk  = 1'b1;
            ser_data = 1'b0;
            cycles(4);
            ser_clk  = 1'b0;
            ser_data = 1'b1;
            cycles(4);
        end
        ser_data = 1'b0;
        latch(0);
        latch(1);
        check("edge_fall_word", fv_data, 32'hFFFF_FFFF);
        check("edge_rise_word", fv_data_r, 32'h0000_0000);
        wb_xfer(3'd0, 1'b1, 32'h11, rd);

        // Overflow: 17 frames into a 16-deep FIFO.
        for (int k = 1; k <= 17; k++) frame(16'(k), 16'(16'h100 + k));
        status_is("ovf_status", 32'h0000_100D);
        wb_xfer(3'd1, 1'b0, 32'd0, rd);
        check("ovf_first_ch0", rd, 32'h0000_0001);
        wb_xfer(3'd2, 1'b0, 32'd0, rd);
        check("ovf_first_ch1", rd, 32'h0000_0101);
        wb_xfer(3'd0, 1'b1, 32'h09, rd);
        status_is("ovf_cleared", 32'h0000_0F01);

        frame(16'h0012, 16'h0112);
        status_is("refull_status", 32'h0000_1005);
        latch(0);
        aligned_frame_access(3'd2, 1'b0, 32'd0, rd);
        check("pop_push_head", rd, 32'h0000_0102);
        status_is("pop_push_status", 32'h0000_1005);
        latch(0);
        aligned_frame_access(3'd0, 1'b1, 32'h11, rd);
        status_is("flush_push_status", 32'h0000_0003);

        // Reset mid-frame discards the partial latch set.
        shift_word(16'h5555);
        latch(0);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(10);
        c0 = fv_count;
        latch(1);
        cycles(10);
        check("rst_partial_no_fv", 32'(fv_count - c0), 32'd0);
        status_is("rst_partial_status", 32'h0000_0003);
        latch(0);
        latch(1);
        cycles(4);
        check("rst_full_set_fv", 32'(fv_count - c0), 32'd1);
        status_is("rst_full_set_status", 32'h0000_0101);
        wb_xfer(3'd0, 1'b1, 32'h11, rd);

        // Disabled: frames still pulse but are not pushed.
        wb_xfer(3'd0, 1'b1, 32'h00, rd);
        c0 = fv_count;
        for (int k = 0; k < 3; k++) begin
            latch(0);
            latch(1);
        end
        check("disabled_fv_count", 32'(fv_count - c0), 32'd3);
        status_is("disabled_status", 32'h0000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
